// File: rtl/mux8_arbiter.sv
// Round-robin arbiter for a shared 8:1 mux. Each grant is a bounded burst of
// registered mux samples, followed by a one-cycle RELEASE and an IDLE arbitration edge.
module mux8_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       y_q,
  output logic       y_valid
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] last;
  logic [3:0] count;
  logic [2:0] winner;
  logic       burst_done;

  // The search starts just after the previous winner, so it wraps 7 -> 0 naturally in 3 bits.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + k[2:0];
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign burst_done = (count + 4'd1) == 4'(MAX_BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req) next_state = GRANT;
      GRANT:   if (!req[sel] || burst_done) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    gnt  = (state == GRANT) ? (8'd1 << sel) : 8'd0;
    busy = (state != IDLE);
  end

  // sel holds through RELEASE and IDLE; it only moves on an arbitration edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= 3'd0;
      last    <= 3'd7;
      count   <= 4'd0;
      y_q     <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            sel   <= winner;
            last  <= winner;
            count <= 4'd0;
          end
        end
        GRANT: begin
          if (req[sel]) begin
            y_q     <= d[sel];
            y_valid <= 1'b1;
            count   <= count + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_arbiter.sv
// Directed bench for mux8_arbiter: a transaction-level model checked every cycle,
// plus hand-computed expectations for grant order, sample counts and reset.
module tb_mux8_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] d = 8'h00;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       y_q;
  logic       y_valid;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  bit gnt_seen = 0;
  int grants[$];

  mux8_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .sel(sel), .gnt(gnt), .busy(busy), .y_q(y_q), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  // Model: who owns the mux, how many samples it has taken, and whether a release cycle is pending.
  int         m_owner = -1;
  int         m_samples = 0;
  int         m_last = 7;
  bit         m_rel = 0;
  logic [2:0] m_sel = 3'd0;
  logic       m_yq = 1'b0;
  logic       m_yv = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int c;
    if (!rst_n) begin
      m_owner = -1; m_samples = 0; m_last = 7; m_rel = 0;
      m_sel = 3'd0; m_yq = 1'b0; m_yv = 1'b0;
    end else if (m_owner >= 0) begin
      if (req[m_owner]) begin
        m_yq = d[m_owner];
        m_yv = 1'b1;
        m_samples++;
        if (m_samples == MB) begin
          m_owner = -1;
          m_rel = 1;
        end
      end else begin
        m_yv = 1'b0;
        m_owner = -1;
        m_rel = 1;
      end
    end else if (m_rel) begin
      m_rel = 0;
      m_yv = 1'b0;
    end else begin
      m_yv = 1'b0;
      if (req != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          c = (m_last + k) % 8;
          if (req[c]) begin
            m_owner = c;
            break;
          end
        end
        m_sel = 3'(m_owner);
        m_last = m_owner;
        m_samples = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_gnt", gnt, (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0);
    checkOutput("model_sel", {5'd0, sel}, {5'd0, m_sel});
    checkOutput("model_busy", {7'd0, busy}, {7'd0, (m_owner >= 0) || m_rel});
    checkOutput("model_y_valid", {7'd0, y_valid}, {7'd0, m_yv});
    checkOutput("model_y_q", {7'd0, y_q}, {7'd0, m_yq});
  end

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] dv);
    @(negedge clk);
    req = r;
    d = dv;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (gnt != 8'h00 && !gnt_seen) grants.push_back(int'(sel));
    gnt_seen = (gnt != 8'h00);
    if (y_valid) pulses++;
  endtask

  task automatic runCycles(input int n);
    repeat (n) stepCycle();
  endtask

  task automatic clearStats();
    pulses = 0;
    grants.delete();
    gnt_seen = 0;
  endtask

  task automatic checkGrants(input string name, input int exp[$]);
    checkOutput({name, "_count"}, 8'(grants.size()), 8'(exp.size()));
    for (int i = 0; i < exp.size() && i < grants.size(); i++)
      checkOutput({name, "_order"}, 8'(grants[i]), 8'(exp[i]));
  endtask

  logic [7:0] nd;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_gnt", gnt, 8'h00);
    checkOutput("reset_sel", {5'd0, sel}, 8'h00);
    checkOutput("reset_busy", {7'd0, busy}, 8'h00);
    checkOutput("reset_y_q", {7'd0, y_q}, 8'h00);
    checkOutput("reset_y_valid", {7'd0, y_valid}, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // Single requester 7: one full burst of zero samples.
    applyStimulus(8'h80, 8'b0101_0101);
    clearStats();
    stepCycle();
    checkOutput("basic_gnt", gnt, 8'h80);
    checkOutput("basic_sel", {5'd0, sel}, 8'd7);
    runCycles(MB);
    checkOutput("basic_pulses", 8'(pulses), 8'd4);
    checkOutput("basic_y_q", {7'd0, y_q}, 8'd0);
    checkOutput("basic_release_gnt", gnt, 8'h00);
    checkOutput("basic_release_busy", {7'd0, busy}, 8'd1);
    applyStimulus(8'h00, 8'b0101_0101);
    runCycles(1);
    checkOutput("basic_idle_busy", {7'd0, busy}, 8'd0);
    checkOutput("basic_idle_y_valid", {7'd0, y_valid}, 8'd0);

    // Requesters 0 and 5 alternate.
    applyStimulus(8'h21, 8'b0010_0001);
    clearStats();
    runCycles(24);
    checkGrants("rr", '{0, 5, 0, 5});
    checkOutput("rr_pulses", 8'(pulses), 8'd16);
    checkOutput("rr_y_q", {7'd0, y_q}, 8'd1);
    applyStimulus(8'h00, 8'b0010_0001);

    // Requester 2 drops out after two samples.
    applyStimulus(8'h04, 8'h04);
    clearStats();
    runCycles(3);
    applyStimulus(8'h00, 8'h04);
    runCycles(1);
    checkOutput("early_busy_release", {7'd0, busy}, 8'd1);
    checkOutput("early_gnt_release", gnt, 8'h00);
    runCycles(1);
    checkGrants("early", '{2});
    checkOutput("early_pulses", 8'(pulses), 8'd2);
    checkOutput("early_busy_idle", {7'd0, busy}, 8'd0);

    // Grant 6, then req 0x41 must wrap to 0 before returning to 6.
    applyStimulus(8'h40, 8'h41);
    clearStats();
    runCycles(6);
    applyStimulus(8'h41, 8'h41);
    runCycles(12);
    checkGrants("wrap", '{6, 0, 6});
    checkOutput("wrap_pulses", 8'(pulses), 8'd12);

    // Requester 3 with d[3] toggling and the other bits scrambled.
    applyStimulus(8'h08, 8'h00);
    clearStats();
    stepCycle();
    checkOutput("data_sel", {5'd0, sel}, 8'd3);
    for (int i = 0; i < MB; i++) begin
      nd = (8'($urandom_range(0, 255)) & 8'hF7) | {4'd0, ~d[3], 3'd0};
      applyStimulus(8'h08, nd);
      stepCycle();
      checkOutput("data_y_q", {7'd0, y_q}, {7'd0, nd[3]});
    end
    applyStimulus(8'h00, 8'h00);
    runCycles(2);
    checkOutput("data_pulses", 8'(pulses), 8'd4);

    // Reset in the middle of a burst to requester 2.
    applyStimulus(8'h04, 8'hFF);
    runCycles(2);
    #1;
    checkOutput("midrst_pre_gnt", gnt, 8'h04);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_gnt", gnt, 8'h00);
    checkOutput("midrst_sel", {5'd0, sel}, 8'd0);
    checkOutput("midrst_y_valid", {7'd0, y_valid}, 8'd0);
    checkOutput("midrst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h81;
    clearStats();
    stepCycle();
    checkOutput("postrst_gnt", gnt, 8'h01);
    checkOutput("postrst_sel", {5'd0, sel}, 8'd0);
    runCycles(5);
    applyStimulus(8'h00, 8'hFF);
    runCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
